// File: rtl/shift_reg_univ_pkg.sv
// Shared mode constants, FSM state encoding and helpers for the universal shift register.
package shift_reg_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Shift and rotate modes are the contiguous range SHR..ASR.
  function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
    return (m >= MODE_SHR) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Command/data bundle between a shift_reg_univ client (master) and the register (slave).
interface shift_reg_univ_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned AW = $clog2(WIDTH + 1);

  logic [2:0]       M;
  logic [WIDTH-1:0] D;
  logic             si;
  logic             start;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] Q;
  logic             so;
  logic             busy;
  logic             done;

  modport master (
    output M, D, si, start, amt,
    input  Q, so, busy, done
  );

  modport slave (
    input  M, D, si, start, amt,
    output Q, so, busy, done
  );
endinterface

// File: rtl/shift_reg_univ_step.sv
// One combinational shift/rotate step; hold, load and reserved modes pass q through.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_si,
  input  logic [WIDTH-1:0]  i_q,
  output logic [WIDTH-1:0]  o_q_next,
  output logic              o_so_next,
  output logic              o_is_shift
);

  always_comb begin
    o_q_next   = i_q;
    o_so_next  = 1'b0;
    o_is_shift = 1'b0;
    case (i_mode)
      MODE_SHR: begin
        o_q_next   = {i_si, i_q[WIDTH-1:1]};
        o_so_next  = i_q[0];
        o_is_shift = 1'b1;
      end
      MODE_SHL: begin
        o_q_next   = {i_q[WIDTH-2:0], i_si};
        o_so_next  = i_q[WIDTH-1];
        o_is_shift = 1'b1;
      end
      MODE_ROR: begin
        o_q_next   = {i_q[0], i_q[WIDTH-1:1]};
        o_so_next  = i_q[0];
        o_is_shift = 1'b1;
      end
      MODE_ROL: begin
        o_q_next   = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_so_next  = i_q[WIDTH-1];
        o_is_shift = 1'b1;
      end
      MODE_ASR: begin
        o_q_next   = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
        o_so_next  = i_q[0];
        o_is_shift = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with single-step modes and a multi-cycle "shift by N" command.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_reg_univ_if.slave        bus
);

  localparam int unsigned AW = $clog2(WIDTH + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDTH-1:0]    r_q;
  logic [WIDTH-1:0]    w_q_next;
  logic                r_so;
  logic                w_so_next;
  logic [AW-1:0]       r_cnt;
  logic [AW-1:0]       w_cnt_next;
  logic [MODE_W-1:0]   r_mode_l;
  logic [MODE_W-1:0]   w_mode_l_next;
  logic                r_si_l;
  logic                w_si_l_next;

  logic [MODE_W-1:0]   w_step_mode;
  logic                w_step_si;
  logic [WIDTH-1:0]    w_step_q;
  logic                w_step_so;
  logic                w_step_is_shift;
  logic [AW-1:0]       w_amt_clamped;

  // The single stepper serves both the legacy per-edge path and the latched command.
  assign w_step_mode = (r_state == RUN) ? r_mode_l : bus.M;
  assign w_step_si   = (r_state == RUN) ? r_si_l   : bus.si;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_mode     (w_step_mode),
    .i_si       (w_step_si),
    .i_q        (r_q),
    .o_q_next   (w_step_q),
    .o_so_next  (w_step_so),
    .o_is_shift (w_step_is_shift)
  );

  assign w_amt_clamped = (bus.amt > AW'(WIDTH)) ? AW'(WIDTH) : bus.amt;

  // State, data and command registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_so     <= 1'b0;
      r_cnt    <= '0;
      r_mode_l <= MODE_HOLD;
      r_si_l   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_q      <= w_q_next;
      r_so     <= w_so_next;
      r_cnt    <= w_cnt_next;
      r_mode_l <= w_mode_l_next;
      r_si_l   <= w_si_l_next;
    end
  end

  // Next-state and datapath selection.
  always_comb begin
    w_state_next  = r_state;
    w_q_next      = r_q;
    w_so_next     = r_so;
    w_cnt_next    = r_cnt;
    w_mode_l_next = r_mode_l;
    w_si_l_next   = r_si_l;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          // Command capture edge: Q and so are left untouched.
          w_mode_l_next = bus.M;
          w_si_l_next   = bus.si;
          w_cnt_next    = w_amt_clamped;
          if ((w_amt_clamped != '0) && is_shift_mode(bus.M)) begin
            w_state_next = RUN;
          end else begin
            w_state_next = DONE;
          end
        end else if (bus.M == MODE_LOAD) begin
          w_q_next = bus.D;
        end else begin
          w_q_next = w_step_q;
          if (w_step_is_shift) begin
            w_so_next = w_step_so;
          end
        end
      end
      RUN: begin
        w_q_next   = w_step_q;
        w_so_next  = w_step_so;
        w_cnt_next = r_cnt - AW'(1);
        if (r_cnt == AW'(1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.Q    = r_q;
  assign bus.so   = r_so;
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ at WIDTH=8.
module tb_shift_reg_univ;
  import shift_reg_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  shift_reg_univ_if #(.WIDTH(WIDTH)) bus ();

  shift_reg_univ #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until done is seen or the limit expires, counting busy samples.
  task automatic wait_done(input int limit, output int busy_cyc, output bit seen);
    busy_cyc = 0;
    seen     = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busy_cyc++;
      tick();
    end
  endtask

  task automatic load(input logic [7:0] val);
    bus.M = MODE_LOAD;
    bus.D = val;
    tick();
    bus.M = MODE_HOLD;
  endtask

  int busy_cyc;
  bit seen;
  int done_cnt;

  initial begin
    reset     = 1'b1;
    bus.M     = MODE_HOLD;
    bus.D     = '0;
    bus.si    = 1'b0;
    bus.start = 1'b0;
    bus.amt   = '0;
    tick();
    check("rst_q",    32'(bus.Q),    32'h00);
    check("rst_so",   32'(bus.so),   32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    reset = 1'b0;

    // Single steps.
    load(8'hB5);
    check("load_q",    32'(bus.Q),    32'hB5);
    check("load_so",   32'(bus.so),   32'h0);
    check("load_busy", 32'(bus.busy), 32'h0);

    bus.M = MODE_SHR; bus.si = 1'b1; tick();
    check("shr_q",  32'(bus.Q),  32'hDA);
    check("shr_so", 32'(bus.so), 32'h1);
    bus.M = MODE_SHL; bus.si = 1'b0; tick();
    check("shl_q",  32'(bus.Q),  32'hB4);
    check("shl_so", 32'(bus.so), 32'h1);
    bus.M = MODE_ASR; tick();
    check("asr_q",  32'(bus.Q),  32'hDA);
    check("asr_so", 32'(bus.so), 32'h0);
    bus.M = MODE_ROL; tick();
    check("rol_q",  32'(bus.Q),  32'hB5);
    check("rol_so", 32'(bus.so), 32'h1);
    bus.M = MODE_HOLD; tick();
    check("hold_q",  32'(bus.Q),  32'hB5);
    check("hold_so", 32'(bus.so), 32'h1);
    bus.M = 3'b111; tick();
    check("rsvd_q",  32'(bus.Q),  32'hB5);
    check("rsvd_so", 32'(bus.so), 32'h1);

    // Multi-cycle rotate right by 3; bus noise during busy must be ignored.
    load(8'h81);
    check("load81_so_kept", 32'(bus.so), 32'h1);
    bus.M = MODE_ROR; bus.amt = 4'd3; bus.start = 1'b1; tick();
    check("ror_t0_q",    32'(bus.Q),    32'h81);
    check("ror_t0_busy", 32'(bus.busy), 32'h1);
    check("ror_t0_done", 32'(bus.done), 32'h0);
    bus.start = 1'b0; bus.M = MODE_LOAD; bus.D = 8'h55; tick();
    check("ror_t1_q",    32'(bus.Q),    32'hC0);
    check("ror_t1_so",   32'(bus.so),   32'h1);
    check("ror_t1_busy", 32'(bus.busy), 32'h1);
    bus.M = MODE_SHL; bus.D = 8'hAA; bus.start = 1'b1; tick();
    check("ror_t2_q",    32'(bus.Q),    32'h60);
    check("ror_t2_busy", 32'(bus.busy), 32'h1);
    bus.start = 1'b0; tick();
    check("ror_t3_q",    32'(bus.Q),    32'h30);
    check("ror_t3_so",   32'(bus.so),   32'h0);
    check("ror_t3_busy", 32'(bus.busy), 32'h0);
    check("ror_t3_done", 32'(bus.done), 32'h1);
    bus.M = MODE_HOLD; tick();
    check("ror_t4_done", 32'(bus.done), 32'h0);
    check("ror_t4_q",    32'(bus.Q),    32'h30);

    // Clamped SHR: amt=15 becomes 8 shifts of si_l=0.
    load(8'hFF);
    bus.M = MODE_SHR; bus.si = 1'b0; bus.amt = 4'd15; bus.start = 1'b1; tick();
    bus.start = 1'b0; bus.si = 1'b1; bus.M = MODE_HOLD;
    wait_done(20, busy_cyc, seen);
    check("clamp_done_seen", 32'(seen),     32'h1);
    check("clamp_busy_cyc",  32'(busy_cyc), 32'd8);
    check("clamp_q",         32'(bus.Q),    32'h00);
    check("clamp_so",        32'(bus.so),   32'h1);
    bus.si = 1'b0; tick();

    // Full-width rotate leaves Q unchanged.
    load(8'hA5);
    bus.M = MODE_ROL; bus.amt = 4'd8; bus.start = 1'b1; tick();
    bus.start = 1'b0; bus.M = MODE_HOLD;
    wait_done(20, busy_cyc, seen);
    check("rol8_done_seen", 32'(seen),     32'h1);
    check("rol8_busy_cyc",  32'(busy_cyc), 32'd8);
    check("rol8_q",         32'(bus.Q),    32'hA5);
    check("rol8_so",        32'(bus.so),   32'h1);
    tick();

    // Degenerate commands: zero count, then a non-shift mode.
    load(8'h3C);
    bus.M = MODE_SHR; bus.amt = 4'd0; bus.start = 1'b1; tick();
    bus.start = 1'b0; bus.M = MODE_HOLD;
    check("deg0_q",    32'(bus.Q),    32'h3C);
    check("deg0_done", 32'(bus.done), 32'h1);
    check("deg0_busy", 32'(bus.busy), 32'h0);
    tick();
    check("deg0_after", 32'(bus.done), 32'h0);
    bus.M = MODE_LOAD; bus.D = 8'hFF; bus.amt = 4'd4; bus.start = 1'b1; tick();
    bus.start = 1'b0; bus.M = MODE_HOLD;
    check("degld_q",    32'(bus.Q),    32'h3C);
    check("degld_done", 32'(bus.done), 32'h1);
    check("degld_busy", 32'(bus.busy), 32'h0);
    tick();
    check("degld_after", 32'(bus.done), 32'h0);

    // Reset during the third busy cycle aborts without a done pulse.
    load(8'hF0);
    bus.M = MODE_SHL; bus.si = 1'b1; bus.amt = 4'd6; bus.start = 1'b1; tick();
    bus.start = 1'b0; bus.M = MODE_HOLD;
    tick();
    check("abort_t1_q", 32'(bus.Q), 32'hE1);
    tick();
    check("abort_t2_q",    32'(bus.Q),    32'hC3);
    check("abort_t2_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1; tick();
    reset = 1'b0;
    check("abort_q",    32'(bus.Q),    32'h00);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    check("abort_so",   32'(bus.so),   32'h0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // A fresh command is accepted normally after the abort.
    load(8'h81);
    bus.M = MODE_ROL; bus.amt = 4'd1; bus.start = 1'b1; tick();
    bus.start = 1'b0; bus.M = MODE_HOLD;
    check("post_t0_busy", 32'(bus.busy), 32'h1);
    tick();
    check("post_t1_q",    32'(bus.Q),    32'h03);
    check("post_t1_so",   32'(bus.so),   32'h1);
    check("post_t1_done", 32'(bus.done), 32'h1);
    tick();
    check("post_t2_done", 32'(bus.done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
